// File: rtl/camera_emulator.sv
// camera_emulator: synthetic RGB565 vsync/href byte-stream source with selectable test patterns.
// Define CAM_EMU_BOX_EN to build the moving-box pattern (pattern_sel = 3); otherwise pattern 3 is black.
module camera_emulator #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int BAR_W       = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       continuous,
  input  logic [1:0] pattern_sel,
  output logic       cam_vsync,
  output logic       cam_href,
  output logic [7:0] cam_data,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);
  localparam logic [15:0] L_LAST   = 16'(2*H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0] A_LAST   = 16'(2*H_ACTIVE - 1);
  localparam logic [15:0] VS_LAST  = 16'(VSYNC_LINES - 1);
  localparam logic [15:0] VB_LAST  = 16'(V_BACK - 1);
  localparam logic [15:0] VA_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VF_LAST  = 16'(V_FRONT - 1);
  localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT} state_t;

  state_t      state_q, state_d;
  logic [15:0] cyc_q, cyc_d, line_q, line_d, px_q, px_d, bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic        byte_sel_q, byte_sel_d;
  logic [1:0]  pat_q, pat_d;
  logic [7:0]  fc_q, fc_d, data_q, data_d;
  logic        vsync_q, vsync_d, href_q, href_d, busy_q, busy_d, done_q, done_d;
  logic        eol, last_line;
  logic [15:0] pix, box_pix;

  assign eol       = cyc_q == L_LAST;
  assign last_line = line_q == (state_q == VSYNC ? VS_LAST : state_q == VBACK ? VB_LAST :
                                state_q == VFRONT ? VF_LAST : VA_LAST);

`ifdef CAM_EMU_BOX_EN
  localparam logic [15:0] BX_MAX = 16'(H_ACTIVE - 16);
  localparam logic [15:0] BY_MAX = 16'(V_ACTIVE - 16);
  logic [15:0] bx_q, bx_d, by_q, by_d;
  assign box_pix = (px_d >= bx_q && px_d < bx_q + 16'd16 && line_d >= by_q && line_d < by_q + 16'd16)
                   ? 16'hF800 : 16'h0000;
  assign bx_d = done_d ? ((bx_q + 16'd4 > BX_MAX) ? 16'd0 : bx_q + 16'd4) : bx_q;
  assign by_d = done_d ? ((by_q + 16'd2 > BY_MAX) ? 16'd0 : by_q + 16'd2) : by_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bx_q <= '0;
      by_q <= '0;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
    end
`else
  assign box_pix = 16'h0000;
`endif

  // Outputs are computed from the next-state values so they are registered yet cycle-aligned.
  assign pix = pat_d == 2'd0 ? {bar_idx_d[2] ? 5'h1F : 5'h00, bar_idx_d[1] ? 6'h3F : 6'h00,
                                bar_idx_d[0] ? 5'h1F : 5'h00} :
               pat_d == 2'd1 ? {px_d[7:3], line_d[7:2], fc_d[4:0]} :
               pat_d == 2'd2 ? 16'hFFFF : box_pix;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    line_d     = line_q;
    px_d       = px_q;
    byte_sel_d = byte_sel_q;
    bar_cnt_d  = bar_cnt_q;
    bar_idx_d  = bar_idx_q;
    pat_d      = pat_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = VSYNC;
        pat_d   = pattern_sel;
      end
      VSYNC, VBACK, VFRONT: begin
        cyc_d = eol ? '0 : cyc_q + 16'd1;
        if (eol) line_d = last_line ? '0 : line_q + 16'd1;
        if (eol && last_line) state_d = state_q == VSYNC ? VBACK : state_q == VBACK ? ACTIVE :
                                        continuous ? VSYNC : IDLE;
        if (eol && last_line && state_q == VFRONT && continuous) pat_d = pattern_sel;
      end
      ACTIVE: begin
        cyc_d      = cyc_q + 16'd1;
        byte_sel_d = ~byte_sel_q;
        if (byte_sel_q) begin
          px_d      = px_q + 16'd1;
          bar_cnt_d = bar_cnt_q == BAR_LAST ? '0 : bar_cnt_q + 16'd1;
          bar_idx_d = bar_cnt_q == BAR_LAST ? bar_idx_q + 3'd1 : bar_idx_q;
        end
        if (cyc_q == A_LAST) state_d = HBLANK;
      end
      HBLANK: begin
        cyc_d = eol ? '0 : cyc_q + 16'd1;
        if (eol) begin
          px_d      = '0;
          bar_cnt_d = '0;
          bar_idx_d = '0;
          line_d    = last_line ? '0 : line_q + 16'd1;
          state_d   = last_line ? VFRONT : ACTIVE;
        end
      end
      default: ;
    endcase
    done_d  = state_d == VFRONT && cyc_d == L_LAST && line_d == VF_LAST;
    fc_d    = done_d ? fc_q + 8'd1 : fc_q;
    vsync_d = state_d == VSYNC;
    href_d  = state_d == ACTIVE;
    busy_d  = state_d != IDLE;
    data_d  = href_d ? (byte_sel_d ? pix[7:0] : pix[15:8]) : 8'h00;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      line_q     <= '0;
      px_q       <= '0;
      byte_sel_q <= 1'b0;
      bar_cnt_q  <= '0;
      bar_idx_q  <= '0;
      pat_q      <= '0;
      fc_q       <= '0;
      data_q     <= '0;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      line_q     <= line_d;
      px_q       <= px_d;
      byte_sel_q <= byte_sel_d;
      bar_cnt_q  <= bar_cnt_d;
      bar_idx_q  <= bar_idx_d;
      pat_q      <= pat_d;
      fc_q       <= fc_d;
      data_q     <= data_d;
      vsync_q    <= vsync_d;
      href_q     <= href_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end

  assign cam_vsync   = vsync_q;
  assign cam_href    = href_q;
  assign cam_data    = data_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_count = fc_q;
endmodule

// File: tb/tb_camera_emulator.sv
// tb_camera_emulator: randomized bench against a frame-timeline model (time since frame start -> expected outputs).
module tb_camera_emulator;
  localparam int H = 48, V = 20, HB = 8, VS = 1, VB = 2, VF = 1, BW = 6;
  localparam int L = 2*H + HB;
  localparam int F = L*(VS + VB + V + VF);

  logic       clk = 1'b0;
  logic       reset, start, continuous;
  logic [1:0] pattern_sel;
  logic       cam_vsync, cam_href, busy, frame_done;
  logic [7:0] cam_data, frame_count;
  int         n_pass = 0, n_tot = 0;
  bit         m_busy;
  int         m_t, m_pat, m_fc, m_bx, m_by;

  always #5 clk = ~clk;

  camera_emulator #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .VSYNC_LINES(VS),
                    .V_BACK(VB), .V_FRONT(VF), .BAR_W(BW)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .pattern_sel(pattern_sel),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] exp_pix(input int px, input int a);
    int b;
    logic [15:0] p;
    b = px / BW;
    case (m_pat)
      0: p = {b[2] ? 5'h1F : 5'h00, b[1] ? 6'h3F : 6'h00, b[0] ? 5'h1F : 5'h00};
      1: p = {px[7:3], a[7:2], m_fc[4:0]};
      2: p = 16'hFFFF;
`ifdef CAM_EMU_BOX_EN
      default: p = (px >= m_bx && px < m_bx + 16 && a >= m_by && a < m_by + 16) ? 16'hF800 : 16'h0000;
`else
      default: p = 16'h0000;
`endif
    endcase
    return p;
  endfunction

  task automatic compare();
    int k, c, a;
    logic vs, hr, dn;
    logic [7:0] d;
    logic [15:0] p;
    k  = m_t / L;
    c  = m_t % L;
    a  = k - VS - VB;
    vs = m_busy && k < VS;
    hr = m_busy && a >= 0 && a < V && c < 2*H;
    dn = m_busy && m_t == F-1;
    p  = exp_pix(c/2, a);
    d  = hr ? (c % 2 == 0 ? p[15:8] : p[7:0]) : 8'h00;
    chk("ctrl", {12'h0, cam_vsync, cam_href, busy, frame_done}, {12'h0, vs, hr, m_busy, dn});
    chk("data", {8'h0, cam_data}, {8'h0, d});
    chk("fcnt", {8'h0, frame_count}, 16'(m_fc));
  endtask

  task automatic model_reset();
    m_busy = 0; m_t = 0; m_pat = 0; m_fc = 0; m_bx = 0; m_by = 0;
  endtask

  task automatic advance(input logic st, input logic co, input logic [1:0] ps);
    if (!m_busy) begin
      if (st) begin m_busy = 1; m_t = 0; m_pat = int'(ps); end
    end else if (m_t == F-1) begin
      if (co) begin m_t = 0; m_pat = int'(ps); end
      else m_busy = 0;
    end else begin
      m_t++;
      if (m_t == F-1) begin
        m_fc = (m_fc + 1) % 256;
        m_bx = (m_bx + 4 > H - 16) ? 0 : m_bx + 4;
        m_by = (m_by + 2 > V - 16) ? 0 : m_by + 2;
      end
    end
  endtask

  task automatic step(input logic st, input logic co, input logic [1:0] ps);
    start = st; continuous = co; pattern_sel = ps;
    advance(st, co, ps);
    @(negedge clk);
    compare();
  endtask

  // While a frame runs, start and pattern_sel are scrambled to prove they are ignored.
  task automatic run(input int n, input logic co, input logic rnd, input logic [1:0] ps);
    for (int i = 0; i < n; i++)
      step(m_busy ? 1'($urandom) : 1'b0, co, rnd ? 2'($urandom) : ps);
  endtask

  initial begin
    reset = 1; start = 0; continuous = 0; pattern_sel = 0;
    model_reset();
    repeat (3) @(negedge clk);
    compare();
    reset = 0;
    run(20, 0, 1, 0);
    step(1, 0, 2); run(F + 10, 0, 1, 0);
    step(1, 0, 0); run(F + 10, 0, 1, 0);
    step(1, 0, 1); run(F + 10, 0, 1, 0);
    step(1, 0, 3); run(F + 10, 0, 1, 0);
    step(1, 1, 0); run(3*F - 2, 1, 1, 0); run(F + 10, 0, 1, 0);
    step(1, 0, 1); run((VS + VB + 10)*L + 37, 0, 1, 0);
    reset = 1;
    model_reset();
    #1 compare();
    start = 1;
    @(negedge clk);
    compare();
    reset = 0;
    step(1, 0, 2); run(F + 10, 0, 1, 0);
    step(1, 1, 3); run(10*F, 1, 0, 3); run(F + 10, 0, 0, 3);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
